// File: rtl/uart_rx_fifo_wr.sv
// Oversampling UART receiver (8N1, LSB first) that writes each good character
// into the write side of an async FIFO via a one-cycle winc strobe.
module uart_rx_fifo_wr #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  rx,
    input  logic                  wfull,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  winc,
    output logic                  frm_err,
    output logic                  ovr_err,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q;
    logic [1:0]            sync_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bit_idx_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  winc_q;
    logic                  frm_err_q;
    logic                  ovr_err_q;
    logic                  rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            wdata_q   <= '0;
            winc_q    <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            winc_q    <= 1'b0;
            frm_err_q <= 1'b0;
            if (err_clr) begin
                ovr_err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s, shreg_q[DATA_WIDTH-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at mid stop bit so a following start edge is not missed.
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            frm_err_q <= 1'b1;
                            state_q   <= S_BREAK;
                        end else if (wfull) begin
                            ovr_err_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            winc_q  <= 1'b1;
                            wdata_q <= shreg_q;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wdata   = wdata_q;
    assign winc    = winc_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Directed bench for uart_rx_fifo_wr at CLKS_PER_BIT=8, DATA_WIDTH=8.
module tb_uart_rx_fifo_wr;

    localparam int CPB = 8;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       rx = 1'b1;
    logic       wfull = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wdata;
    logic       winc;
    logic       frm_err;
    logic       ovr_err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int         cyc = 0;
    int         winc_cnt = 0;
    int         frm_cnt = 0;
    logic [7:0] last_wdata = 8'h00;
    logic [7:0] prev_wdata = 8'h00;
    int         last_cyc = 0;
    int         prev_cyc = 0;

    uart_rx_fifo_wr #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .rx     (rx),
        .wfull  (wfull),
        .err_clr(err_clr),
        .wdata  (wdata),
        .winc   (winc),
        .frm_err(frm_err),
        .ovr_err(ovr_err),
        .busy   (busy)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    always @(negedge wclk) begin
        if (winc) begin
            winc_cnt   <= winc_cnt + 1;
            prev_wdata <= last_wdata;
            last_wdata <= wdata;
            prev_cyc   <= last_cyc;
            last_cyc   <= cyc;
        end
        if (frm_err) frm_cnt <= frm_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller must be at a negedge; returns at a negedge right after the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge wclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge wclk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge wclk);
        rx = 1'b1;
    endtask

    initial begin
        int base_w;
        int base_f;
        int start_cyc;

        #1;
        chk("rst_wdata", 32'(wdata), 32'h0);
        chk("rst_winc", 32'(winc), 32'h0);
        chk("rst_frm", 32'(frm_err), 32'h0);
        chk("rst_ovr", 32'(ovr_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge wclk);
        wrst = 1'b0;
        repeat (5) @(negedge wclk);

        // 1: single good character, latency 2+4+72+1
        base_w = winc_cnt; base_f = frm_cnt;
        start_cyc = cyc;
        send_byte(8'hA5, 1'b1);
        repeat (6) @(negedge wclk);
        chk("t1_winc_count", 32'(winc_cnt - base_w), 32'd1);
        chk("t1_wdata", 32'(last_wdata), 32'hA5);
        chk("t1_latency", 32'(last_cyc - start_cyc), 32'd79);
        chk("t1_frm", 32'(frm_cnt - base_f), 32'd0);
        chk("t1_wdata_hold", 32'(wdata), 32'hA5);

        // 2: glitch on rx is rejected
        base_w = winc_cnt; base_f = frm_cnt;
        rx = 1'b0;
        repeat (2) @(negedge wclk);
        rx = 1'b1;
        repeat (2) @(negedge wclk);
        chk("t2_busy_high", 32'(busy), 32'h1);
        repeat (10) @(negedge wclk);
        chk("t2_busy_low", 32'(busy), 32'h0);
        chk("t2_winc", 32'(winc_cnt - base_w), 32'd0);
        chk("t2_frm", 32'(frm_cnt - base_f), 32'd0);

        // 3: framing error followed by a held-low line
        base_w = winc_cnt; base_f = frm_cnt;
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge wclk);
        chk("t3_frm_once", 32'(frm_cnt - base_f), 32'd1);
        chk("t3_winc", 32'(winc_cnt - base_w), 32'd0);
        chk("t3_busy_break", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (5) @(negedge wclk);
        chk("t3_busy_released", 32'(busy), 32'h0);
        chk("t3_frm_still_once", 32'(frm_cnt - base_f), 32'd1);

        // 4: overrun while full, sticky until cleared
        base_w = winc_cnt;
        wfull = 1'b1;
        send_byte(8'h81, 1'b1);
        repeat (4) @(negedge wclk);
        chk("t4_no_winc", 32'(winc_cnt - base_w), 32'd0);
        chk("t4_ovr_set", 32'(ovr_err), 32'h1);
        chk("t4_wdata_kept", 32'(wdata), 32'hA5);
        repeat (20) @(negedge wclk);
        chk("t4_ovr_held", 32'(ovr_err), 32'h1);
        err_clr = 1'b1;
        @(negedge wclk);
        err_clr = 1'b0;
        chk("t4_ovr_cleared", 32'(ovr_err), 32'h0);
        wfull = 1'b0;
        base_w = winc_cnt;
        send_byte(8'h81, 1'b1);
        repeat (6) @(negedge wclk);
        chk("t4_winc_after_clr", 32'(winc_cnt - base_w), 32'd1);
        chk("t4_wdata", 32'(last_wdata), 32'h81);

        // 5: back-to-back characters with no idle gap
        base_w = winc_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (6) @(negedge wclk);
        chk("t5_winc_count", 32'(winc_cnt - base_w), 32'd2);
        chk("t5_first", 32'(prev_wdata), 32'h00);
        chk("t5_second", 32'(last_wdata), 32'hFF);
        chk("t5_spacing", 32'(last_cyc - prev_cyc), 32'd80);

        // 6: reset during bit 4 aborts the character
        wfull = 1'b1;
        send_byte(8'h42, 1'b1);
        wfull = 1'b0;
        repeat (4) @(negedge wclk);
        chk("t6_ovr_pre", 32'(ovr_err), 32'h1);
        base_w = winc_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge wclk);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            repeat (CPB) @(negedge wclk);
        end
        rx = 1'b0;
        repeat (4) @(negedge wclk);
        chk("t6_busy_pre", 32'(busy), 32'h1);
        wrst = 1'b1;
        #1;
        chk("t6_rst_wdata", 32'(wdata), 32'h0);
        chk("t6_rst_ovr", 32'(ovr_err), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_winc", 32'(winc), 32'h0);
        chk("t6_rst_frm", 32'(frm_err), 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge wclk);
        wrst = 1'b0;
        repeat (20) @(negedge wclk);
        chk("t6_no_winc_aborted", 32'(winc_cnt - base_w), 32'd0);
        send_byte(8'h5A, 1'b1);
        repeat (6) @(negedge wclk);
        chk("t6_winc_after", 32'(winc_cnt - base_w), 32'd1);
        chk("t6_wdata", 32'(last_wdata), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
